seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
Downstream display stage for the decade counters. Captures four BCD digits, e.g. the O outputs of four cascaded four_bit_decade_counter instances with digit 0 as the least significant. Time-multiplexes the digits onto one common 7-segment bus with per-digit anode enables. Registered outputs, free-running scan, one-cycle anode blanking on every digit change to suppress ghosting.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot; legal range >= 1; 1 means advance every cycle
SEG_ACTIVE_LOW, 1, 1: seg driven inverted (0 = segment lit); 0: seg active-high
AN_ACTIVE_LOW, 1, 1: an driven inverted (0 = digit enabled); 0: an active-high

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
load  input  1  capture strobe for bcd_in
bcd_in  input  16  four BCD digits; [3:0] = digit 0 (LS), [15:12] = digit 3 (MS)
seg  output  7  segment drive; seg[0]=a ... seg[6]=g; polarity per SEG_ACTIVE_LOW
an  output  4  digit enables; an[i] selects digit i; polarity per AN_ACTIVE_LOW
digit_sel  output  2  index of the digit currently on seg
bad_digit  output  1  high while the latched value holds any nibble > 9

Behaviour:
- Reset (reset low, async): prescaler=0, index=0, latched digits=0, bad_digit=0, digit_sel=0, seg all unlit, an all disabled. Both are at their inactive polarity.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. tick is asserted in the cycle where the count equals SCAN_DIV-1.
- Index: on tick, increments 0->1->2->3->0. Wrap is mandatory.
- Latch: on a posedge with load=1, bcd_in is stored. The new value appears on seg starting with the next registered update. load may be held high every cycle. The latch has no effect on the prescaler or index.
- bad_digit: updated only on load. Set to 1 if any nibble of bcd_in > 9. Set to 0 if all nibbles are <= 9.
- Output register, updated every cycle from the current index and the latched value:
  - Cycle after tick (blank slot): an all disabled; seg shows the new digit; digit_sel = new index.
  - All other cycles: an enables only the current index; seg = decode(latched[index]).
  - With SCAN_DIV=1, every cycle is a blank slot, so an stays disabled. This is legal and documented.
- Latency: index change -> seg/digit_sel change after 1 cycle. load -> seg change after at most 2 cycles if the index is already selected.
- Decode, active-high gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Values 10..15 show a dash, 40 (segment g only). The result is inverted on the port when SEG_ACTIVE_LOW=1.
- Simultaneous load and tick: both take effect. The new index displays the newly latched value on the following update.
- Reset mid-scan: all state returns immediately to reset values. Scanning restarts at digit 0 with a full SCAN_DIV slot.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digit i (i=3..1) is blanked (seg all unlit, an still enabled for the slot) when latched digit i and all higher digits equal 0. Digit 0 is never blanked, so value 0000 shows a single "0". A dash digit counts as non-zero.
- Undefined: every digit is always decoded. 0042 shows "0","0","4","2".

Test Plan:
- Reset check: hold reset low, toggle clk 10 cycles. Expect seg=7F, an=F (active-low defaults), digit_sel=0, bad_digit=0. Assert reset low asynchronously mid-cycle; outputs must return to these values without waiting for a clk edge.
- Scan order and timing (SCAN_DIV=4): load 16'h1234, run 40 cycles. digit_sel steps 0,1,2,3,0 every 4 cycles. The an enable pattern (active-low) walks E,D,B,7 with an=F on the first cycle of each slot. seg shows the active-low codes for 4,3,2,1 in turn (digit_sel 0,1,2,3 = 66,4F,5B,06 inverted).
- All-digit decode: load 16'h9876 and then 16'h5043. Every slot's seg equals the table value (inverted) for the latched digit.
- Invalid BCD: load 16'h00A5. bad_digit=1 after the load edge; digit 1 shows dash (active-low 3F). Then load 16'h0005; bad_digit returns to 0.
- Load on tick edge: assert load with 16'h0009 exactly on a tick cycle while digit_sel goes 3->0. The next digit 0 slot shows 9 (active-low 10), not the old value.
- LEADING_ZERO_BLANK_EN: load 16'h0042. With the macro, digits 3 and 2 have seg=7F (unlit) while an is enabled. Without it, they show "0" (active-low 40). Load 16'h0000: digit 0 shows "0" in both builds.

Source files
------------

// File: rtl/seven_seg_scan_driver_if.sv
// Display bus for seven_seg_scan_driver: BCD capture strobe/data in, segment/anode drive out.
`timescale 1ns/1ps
interface seven_seg_scan_driver_if;
  logic        load;
  logic [15:0] bcd_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        bad_digit;

  modport master (output load, output bcd_in,
                  input seg, input an, input digit_sel, input bad_digit);
  modport slave  (input load, input bcd_in,
                  output seg, output an, output digit_sel, output bad_digit);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver with one-cycle anode blanking on every digit change.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
`timescale 1ns/1ps
module seven_seg_scan_driver #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  seven_seg_scan_driver_if.slave  bus
);

  localparam int unsigned    PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PMAX    = PW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]     AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic any_bad(input logic [15:0] v);
    return (v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v[11:8] > 4'd9) || (v[15:12] > 4'd9);
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   digits_q, digits_d;
  logic          bad_q, bad_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [1:0]    sel_q, sel_d;
  logic          tick_s;
  logic          lz_s;
  logic [3:0]    nib_s;
  logic [6:0]    seg_hi_s;
  logic [3:0]    an_hi_s;

  // Scan timing, digit latch and next output image; outputs track the post-edge index/latch.
  always_comb begin
    tick_s   = (presc_q == PMAX);
    presc_d  = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
    idx_d    = tick_s ? idx_q + 2'd1 : idx_q;
    digits_d = digits_q;
    bad_d    = bad_q;
    if (bus.load) begin
      digits_d = bus.bcd_in;
      bad_d    = any_bad(bus.bcd_in);
    end else begin
      digits_d = digits_q;
      bad_d    = bad_q;
    end

    nib_s = 4'd0;
    lz_s  = 1'b0;
    case (idx_d)
      2'd0:    nib_s = digits_d[3:0];
      2'd1:    nib_s = digits_d[7:4];
      2'd2:    nib_s = digits_d[11:8];
      2'd3:    nib_s = digits_d[15:12];
      default: nib_s = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // A dash nibble is non-zero, so it stops blanking of the digits below it.
    case (idx_d)
      2'd3:    lz_s = (digits_d[15:12] == 4'd0);
      2'd2:    lz_s = (digits_d[15:8]  == 8'd0);
      2'd1:    lz_s = (digits_d[15:4]  == 12'd0);
      default: lz_s = 1'b0;
    endcase
`else
    lz_s = 1'b0;
`endif
    seg_hi_s = lz_s ? 7'h00 : decode(nib_s);
    an_hi_s  = tick_s ? 4'h0 : (4'b0001 << idx_d);
    seg_d    = SEG_ACTIVE_LOW ? ~seg_hi_s : seg_hi_s;
    an_d     = AN_ACTIVE_LOW ? ~an_hi_s : an_hi_s;
    sel_d    = idx_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= {PW{1'b0}};
      idx_q    <= 2'd0;
      digits_q <= 16'h0000;
      bad_q    <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
      sel_q    <= 2'd0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      bad_q    <= bad_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      sel_q    <= sel_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.digit_sel = sel_q;
  assign bus.bad_digit = bad_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed table-driven bench for seven_seg_scan_driver (SCAN_DIV=4, plus a SCAN_DIV=1 copy).
`timescale 1ns/1ps
module tb_seven_seg_scan_driver;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_seg_scan_driver_if ifm();
  seven_seg_scan_driver_if ifs();
  assign ifs.load   = ifm.load;
  assign ifs.bcd_in = ifm.bcd_in;

  seven_seg_scan_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(ifm));
  seven_seg_scan_driver #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(ifs));

  typedef struct {
    logic        ld;
    logic [15:0] bcd;
    int          n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  sel;
    logic        bad;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [6:0] z(input logic [6:0] s);
    return LZB ? 7'h7F : s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] b);
    ifm.load   = ld;
    ifm.bcd_in = b;
    @(posedge clk);
    #1;
    ifm.load = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] s, input logic [3:0] a,
                            input logic [1:0] d, input logic b);
    chk({tag, ".seg"}, 32'(ifm.seg), 32'(s));
    chk({tag, ".an"}, 32'(ifm.an), 32'(a));
    chk({tag, ".digit_sel"}, 32'(ifm.digit_sel), 32'(d));
    chk({tag, ".bad_digit"}, 32'(ifm.bad_digit), 32'(b));
    chk({tag, ".div1_an"}, 32'(ifs.an), 32'(4'hF));
  endtask

  initial begin
    // k = edges since reset release; slot blank (an=F) whenever k%4 == 0
    tbl.push_back('{1'b1, 16'h1234, 3, 7'h19, 4'hE, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 16'h1234, 1, 7'h30, 4'hF, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 16'h1234, 3, 7'h30, 4'hD, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 16'h1234, 1, 7'h24, 4'hF, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 16'h1234, 3, 7'h24, 4'hB, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 16'h1234, 1, 7'h79, 4'hF, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 16'h1234, 3, 7'h79, 4'h7, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 16'h1234, 1, 7'h19, 4'hF, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 16'h9876, 3, 7'h02, 4'hE, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 16'h9876, 1, 7'h78, 4'hF, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 16'h9876, 3, 7'h78, 4'hD, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 16'h9876, 1, 7'h00, 4'hF, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 16'h9876, 3, 7'h00, 4'hB, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 16'h9876, 1, 7'h10, 4'hF, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 16'h9876, 3, 7'h10, 4'h7, 2'd3, 1'b0});
    tbl.push_back('{1'b1, 16'h5043, 1, 7'h30, 4'hF, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 16'h5043, 3, 7'h30, 4'hE, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 16'h5043, 1, 7'h19, 4'hF, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 16'h5043, 3, 7'h19, 4'hD, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 16'h5043, 1, 7'h40, 4'hF, 2'd2, 1'b0});
    tbl.push_back('{1'b1, 16'h00A5, 3, z(7'h40), 4'hB, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 16'h00A5, 1, z(7'h40), 4'hF, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 16'h00A5, 3, z(7'h40), 4'h7, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 16'h00A5, 1, 7'h12, 4'hF, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 16'h00A5, 3, 7'h12, 4'hE, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 16'h00A5, 1, 7'h3F, 4'hF, 2'd1, 1'b1});
    tbl.push_back('{1'b1, 16'h0005, 3, z(7'h40), 4'hD, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 16'h0005, 1, z(7'h40), 4'hF, 2'd2, 1'b0});

    reset      = 1'b0;
    ifm.load   = 1'b0;
    ifm.bcd_in = 16'h0000;
    repeat (10) @(posedge clk);
    #1;
    expect_out("reset_hold", 7'h7F, 4'hF, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        step((j == 0) ? tbl[i].ld : 1'b0, tbl[i].bcd);
        expect_out($sformatf("vec%0d_%0d", i, j), tbl[i].seg, tbl[i].an, tbl[i].sel, tbl[i].bad);
      end
    end

    // load coincident with the 3->0 tick: the new digit 0 slot shows the new value at once
    repeat (6) step(1'b0, 16'h0005);
    step(1'b0, 16'h0005);
    expect_out("pre_tick", z(7'h40), 4'h7, 2'd3, 1'b0);
    step(1'b1, 16'h0009);
    expect_out("load_on_tick", 7'h10, 4'hF, 2'd0, 1'b0);
    step(1'b0, 16'h0009);
    expect_out("load_on_tick_en", 7'h10, 4'hE, 2'd0, 1'b0);

    // leading-zero handling with 0042, then 0000
    step(1'b1, 16'h0042);
    expect_out("lz42_d0", 7'h24, 4'hE, 2'd0, 1'b0);
    step(1'b0, 16'h0042);
    step(1'b0, 16'h0042);
    expect_out("lz42_d1_blank", 7'h19, 4'hF, 2'd1, 1'b0);
    repeat (3) step(1'b0, 16'h0042);
    step(1'b0, 16'h0042);
    expect_out("lz42_d2_blank", z(7'h40), 4'hF, 2'd2, 1'b0);
    step(1'b0, 16'h0042);
    expect_out("lz42_d2", z(7'h40), 4'hB, 2'd2, 1'b0);
    repeat (2) step(1'b0, 16'h0042);
    step(1'b0, 16'h0042);
    expect_out("lz42_d3_blank", z(7'h40), 4'hF, 2'd3, 1'b0);
    step(1'b1, 16'h0000);
    expect_out("lz00_d3", z(7'h40), 4'h7, 2'd3, 1'b0);
    repeat (2) step(1'b0, 16'h0000);
    step(1'b0, 16'h0000);
    expect_out("lz00_d0_blank", 7'h40, 4'hF, 2'd0, 1'b0);
    step(1'b0, 16'h0000);
    expect_out("lz00_d0", 7'h40, 4'hE, 2'd0, 1'b0);

    // asynchronous reset mid-cycle, then a full first slot on restart
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_reset", 7'h7F, 4'hF, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 16'h0000);
    expect_out("restart_k1", 7'h40, 4'hE, 2'd0, 1'b0);
    repeat (2) step(1'b0, 16'h0000);
    expect_out("restart_k3", 7'h40, 4'hE, 2'd0, 1'b0);
    step(1'b0, 16'h0000);
    expect_out("restart_k4", z(7'h40), 4'hF, 2'd1, 1'b0);
    chk("div1_sel", 32'(ifs.digit_sel), 32'(2'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
